result_reader: RTL and testbench
================================

# result_reader

Readback sequencer for the multiplier's 8-entry result RAM. Snoops the RAM write port to track which addresses hold products, and on `start` sweeps addresses 0 to DEPTH-1. It issues synchronous RAM reads for every written entry and presents each product with its address on a valid/ready output stream. It is the read-side counterpart to the multiply-and-store control unit and sits between the result RAM and the display/UART path.

## Interface
- `DATA_W`, default 16: RAM word / product width.
- `ADDR_W`, default 3: RAM address width. DEPTH = 2^ADDR_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `w_ram_en` in 1: snooped RAM write enable.
- `w_ram_addr` in ADDR_W: snooped RAM write address.
- `clr` in 1: clear the written-entry bitmap.
- `start` in 1: begin a sweep. Sampled only in IDLE.
- `r_ram_en` out 1: RAM read enable.
- `r_ram_addr` out ADDR_W: RAM read address.
- `r_ram_data` in DATA_W: RAM read data, valid the cycle after `r_ram_en`.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out DATA_W: product.
- `out_addr` out ADDR_W: address of the product.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `st_out` out 3: state code.

## Operation
- Bitmap `vld[DEPTH-1:0]`:
  - `w_ram_en` sets `vld[w_ram_addr]`.
  - `clr` zeroes all bits.
  - If `clr` and a write occur in the same cycle, the written bit ends up set (write wins).
  - Bitmap updates in every state.
- Pointer `ptr` (ADDR_W bits) is reset to 0 on `start`.
- IDLE (000): if `start`, then `ptr`=0 and go to SCAN.
- SCAN (001):
  - if `vld[ptr]`, go to READ;
  - else if `ptr`==DEPTH-1, go to DONE;
  - else `ptr`++ and stay in SCAN.
- READ (010): `r_ram_en`=1, `r_ram_addr`=`ptr`. Go to WAIT.
- WAIT (011): register `out_data`<=`r_ram_data` and `out_addr`<=`ptr`. Go to SEND.
- SEND (100):
  - `out_valid`=1.
  - On `out_ready`: if `ptr`==DEPTH-1 go to DONE, else `ptr`++ and go to SCAN.
  - With `out_ready` low, hold `out_valid`, `out_data` and `out_addr` stable indefinitely.
- DONE (101): `done`=1 for one cycle, then go to IDLE.
- Unused encodings go to IDLE.
- `start` outside IDLE is ignored.
- `clr` mid-sweep does not abort the entry in flight. Later SCAN cycles see the cleared bits.
- A snooped write mid-sweep:
  - to an address > `ptr` is included in the current sweep;
  - to an address ≤ `ptr` is not re-read until the next sweep.
- `ptr` never wraps within a sweep. DEPTH-1 is terminal.

## Timing
- Reset (`rst`=0): state IDLE, `ptr`=0, `vld`=0, and all outputs 0 (`r_ram_en`, `r_ram_addr`, `out_valid`, `out_data`, `out_addr`, `busy`, `done`, `st_out`=000). Reset takes effect immediately, including mid-sweep, where `out_valid` drops without a handshake.
- `start` high at edge k puts the block in SCAN for cycle k+1.
- Written entry at `ptr`: SCAN, READ, WAIT, SEND. `out_valid` rises 3 cycles after that entry's SCAN cycle. Minimum 4 cycles per entry with `out_ready` held high.
- Each unwritten entry costs exactly one SCAN cycle.
- Empty bitmap: 8 SCAN cycles, then DONE. `done` is high 9 cycles after the `start` edge.
- `busy` and `st_out` are combinational decodes of the state register. All other outputs are registered or state-decoded with no input-to-output combinational path.

## Configuration
- `RESULT_READER_CLEAR_ON_READ_EN` defined: the handshake (`out_valid`&`out_ready`) clears `vld[out_addr]`.
  - A snooped write to the same address in that cycle wins, so the bit stays set.
  - A second sweep with no new writes emits nothing.
- Not defined: bits clear only via `clr` or `rst`. Repeated sweeps re-emit the same entries.

## Test plan
- Reset, then write 0x0015 @3 and 0x00F0 @6. Pulse `start` with `out_ready`=1: emits (3,0x0015) then (6,0x00F0). `done` pulses. Total sweep 15 cycles from the `start` edge to `done`.
- Empty bitmap, pulse `start`: no `out_valid`. `done` at start edge +9. `busy` high for 9 cycles.
- Single entry @7, `out_ready` held low for 5 cycles in SEND: `out_valid`, `out_data` and `out_addr` stable throughout. One transfer on release, then DONE.
- `clr` and a write @2 in the same cycle: `vld`=0000_0100. A sweep emits only address 2.
- Mid-sweep (`ptr`=1): write @5 is emitted in the same sweep; write @0 is not. `rst` low during SEND: `out_valid`=0 immediately, state IDLE, bitmap cleared.
- With the macro defined: two back-to-back sweeps over entries @1 and @4. The first emits both, the second emits none and still pulses `done`.

Source files
------------

// File: rtl/result_reader.sv
// -----------------------------------------------------------------------------
// result_reader
//
// Readback sequencer for the multiplier's result RAM. It snoops the RAM write
// port to keep a bitmap of addresses that hold products. On `start` it sweeps
// addresses 0..DEPTH-1, issues a synchronous RAM read for every written entry,
// and presents each product with its address on a valid/ready stream.
//
// Optional build macro:
//   RESULT_READER_CLEAR_ON_READ_EN - an accepted output word clears its bitmap
//                                    bit, so a repeat sweep with no new writes
//                                    emits nothing. A snooped write to the same
//                                    address in that cycle keeps the bit set.
//
// Parameters:
//   DATA_W  RAM word / product width
//   ADDR_W  RAM address width, DEPTH = 2**ADDR_W
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   w_ram_en    snooped RAM write enable
//   w_ram_addr  snooped RAM write address
//   clr         clear the written-entry bitmap
//   start       begin a sweep (sampled only while idle)
//   r_ram_en    RAM read enable
//   r_ram_addr  RAM read address
//   r_ram_data  RAM read data, valid the cycle after r_ram_en
//   out_valid   output word valid
//   out_ready   consumer accepts the word
//   out_data    product
//   out_addr    address of the product
//   busy        high in every state except IDLE
//   done        one-cycle pulse at the end of a sweep
//   st_out      state code
// -----------------------------------------------------------------------------
module result_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_ram_en,
  input  logic [ADDR_W-1:0] w_ram_addr,
  input  logic              clr,
  input  logic              start,
  output logic              r_ram_en,
  output logic [ADDR_W-1:0] r_ram_addr,
  input  logic [DATA_W-1:0] r_ram_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        st_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    SCAN = 3'b001,
    READ = 3'b010,
    WAIT = 3'b011,
    SEND = 3'b100,
    DONE = 3'b101
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  vld_nxt;
  logic              load_out;
  logic              xfer;

  assign xfer = (state == SEND) && out_ready;

  // Bitmap update runs in every state. Order matters: clear first, then the
  // optional clear-on-read, then the snooped write so that a write always wins.
  always_comb begin
    vld_nxt = vld;
    if (clr) begin
      vld_nxt = '0;
    end
`ifdef RESULT_READER_CLEAR_ON_READ_EN
    if (xfer) begin
      vld_nxt[out_addr] = 1'b0;
    end
`else
`endif
    if (w_ram_en) begin
      vld_nxt[w_ram_addr] = 1'b1;
    end
  end

  // Sweep sequencer. The pointer is never incremented past LAST, so a sweep
  // always terminates in DONE without wrapping.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ptr_nxt   = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (vld[ptr]) begin
          state_nxt = READ;
        end else if (ptr == LAST) begin
          state_nxt = DONE;
        end else begin
          ptr_nxt = ptr + ONE;
        end
      end
      READ: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        load_out  = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (ptr == LAST) begin
            state_nxt = DONE;
          end else begin
            ptr_nxt   = ptr + ONE;
            state_nxt = SCAN;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      vld      <= '0;
      out_data <= '0;
      out_addr <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      vld   <= vld_nxt;
      // Output word is captured once in WAIT and then held untouched through
      // any amount of back-pressure in SEND.
      if (load_out) begin
        out_data <= r_ram_data;
        out_addr <= ptr;
      end
    end
  end

  // All outputs are decodes of registered state; no input reaches an output
  // combinationally.
  assign r_ram_en   = (state == READ);
  assign r_ram_addr = (state == READ) ? ptr : '0;
  assign out_valid  = (state == SEND);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);
  assign st_out     = state;

endmodule

// File: tb/tb_result_reader.sv
module tb_result_reader;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w_ram_en = 1'b0;
  logic [AW-1:0] w_ram_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic          r_ram_en;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic [2:0]    st_out;

  result_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .w_ram_en(w_ram_en), .w_ram_addr(w_ram_addr),
    .clr(clr), .start(start), .r_ram_en(r_ram_en), .r_ram_addr(r_ram_addr),
    .r_ram_data(r_ram_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done),
    .st_out(st_out)
  );

  always #5 clk = ~clk;

  // Result RAM: synchronous write, synchronous read with one-cycle latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (w_ram_en) mem[w_ram_addr] <= w_data;
    if (r_ram_en) r_ram_data <= mem[r_ram_addr];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } em_t;

  em_t got[$];
  em_t exp_q[$];

  // Record every handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) got.push_back('{a: out_addr, d: out_data});
  end

  // Reference model: which addresses hold data and what was last written.
  bit            m_vld [DEPTH];
  logic [DW-1:0] m_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] mask;
    int         exp_lat;
    int         exp_n;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    w_ram_en   = 1'b1;
    w_ram_addr = AW'(a);
    w_data     = d;
    tick();
    w_ram_en   = 1'b0;
    m_vld[a]   = 1'b1;
    m_mem[a]   = d;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
  endtask

  task automatic build_exp_from_model();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++)
      if (m_vld[i]) exp_q.push_back('{a: AW'(i), d: m_mem[i]});
  endtask

  task automatic cmp_emits(input string nm);
    chk({nm, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s addr[%0d]", nm, i), 32'(got[i].a), 32'(exp_q[i].a));
      chk($sformatf("%s data[%0d]", nm, i), 32'(got[i].d), 32'(exp_q[i].d));
    end
  endtask

  // Pulse start (edge k) and count cycles until done; busy is counted too.
  task automatic run_sweep(input bit rnd, output int lat, output int busy_cnt);
    got.delete();
    busy_cnt  = 0;
    lat       = -1;
    start     = 1'b1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    tick();
    out_ready = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({nm, " out_valid seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({nm, " done seen"}, 32'(ok), 32'd1);
    tick();
  endtask

  initial begin
    int lat;
    int bc;
    logic [DW-1:0] hd;

    vecs[0] = '{mask: 8'h48, exp_lat: 15, exp_n: 2};
    vecs[1] = '{mask: 8'h00, exp_lat: 9,  exp_n: 0};
    vecs[2] = '{mask: 8'h80, exp_lat: 12, exp_n: 1};
    vecs[3] = '{mask: 8'hFF, exp_lat: 33, exp_n: 8};
    vecs[4] = '{mask: 8'h01, exp_lat: 12, exp_n: 1};
    vecs[5] = '{mask: 8'h81, exp_lat: 15, exp_n: 2};
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0;
      m_mem[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst st_out", 32'(st_out), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst r_ram_en", 32'(r_ram_en), 32'd0);
    chk("rst r_ram_addr", 32'(r_ram_addr), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_addr", 32'(out_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Spec example: 0x0015 @3, 0x00F0 @6
    wr(3, 16'h0015);
    wr(6, 16'h00F0);
    build_exp_from_model();
    run_sweep(1'b0, lat, bc);
    cmp_emits("basic");
    chk("basic lat", 32'(lat), 32'd15);
    do_clr();

    // Table-driven sweeps with out_ready held high
    for (int v = 0; v < 6; v++) begin
      do_clr();
      for (int a = 0; a < DEPTH; a++)
        if (vecs[v].mask[a]) wr(a, 16'hA000 | DW'(v << 8) | DW'(a * 16'h11));
      exp_q.delete();
      for (int a = 0; a < DEPTH; a++)
        if (vecs[v].mask[a]) exp_q.push_back('{a: AW'(a), d: 16'hA000 | DW'(v << 8) | DW'(a * 16'h11)});
      chk($sformatf("vec%0d exp_n", v), exp_q.size(), vecs[v].exp_n);
      run_sweep(1'b0, lat, bc);
      cmp_emits($sformatf("vec%0d", v));
      chk($sformatf("vec%0d lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("vec%0d busy cycles", v), 32'(bc), 32'(vecs[v].exp_lat));
      @(negedge clk);
      chk($sformatf("vec%0d idle after", v), 32'(busy), 32'd0);
      tick();
    end

    // Back-pressure: single entry @7, ready low for 5 cycles in SEND
    do_clr();
    wr(7, 16'hBEEF);
    got.delete();
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("stall");
    for (int c = 0; c < 5; c++) begin
      chk("stall valid", 32'(out_valid), 32'd1);
      chk("stall data", 32'(out_data), 32'hBEEF);
      chk("stall addr", 32'(out_addr), 32'd7);
      tick();
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("stall done after xfer", 32'(done), 32'd1);
    chk("stall xfers", got.size(), 32'd1);
    tick();

    // clr and write @2 in the same cycle: write wins
    do_clr();
    wr(5, 16'h5555);
    clr = 1'b1;
    w_ram_en = 1'b1;
    w_ram_addr = 3'd2;
    w_data = 16'h2222;
    tick();
    clr = 1'b0;
    w_ram_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_vld[2] = 1'b1;
    m_mem[2] = 16'h2222;
    build_exp_from_model();
    run_sweep(1'b0, lat, bc);
    cmp_emits("clr+wr");
    chk("clr+wr lat", 32'(lat), 32'd12);

    // Mid-sweep writes while parked in SEND at ptr=1
    do_clr();
    wr(1, 16'h1111);
    got.delete();
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("mid");
    tick();
    wr(5, 16'h5A5A);
    wr(0, 16'h0A0A);
    out_ready = 1'b1;
    wait_done("mid");
    exp_q.delete();
    exp_q.push_back('{a: 3'd1, d: 16'h1111});
    exp_q.push_back('{a: 3'd5, d: 16'h5A5A});
    cmp_emits("mid");

    // Reset asserted during SEND
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("rstsend");
    #1;
    rst = 1'b0;
    #1;
    chk("rstsend out_valid", 32'(out_valid), 32'd0);
    chk("rstsend st_out", 32'(st_out), 32'd0);
    chk("rstsend busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    tick();
    build_exp_from_model();
    run_sweep(1'b0, lat, bc);
    cmp_emits("post-rst");
    chk("post-rst lat", 32'(lat), 32'd9);

    // Back-to-back sweeps over @1 and @4
    do_clr();
    wr(1, 16'h0101);
    wr(4, 16'h0404);
    build_exp_from_model();
    run_sweep(1'b0, lat, bc);
    cmp_emits("b2b first");
    chk("b2b first lat", 32'(lat), 32'd15);
`ifdef RESULT_READER_CLEAR_ON_READ_EN
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    build_exp_from_model();
    run_sweep(1'b0, lat, bc);
    cmp_emits("b2b second");
    chk("b2b second lat", 32'(lat), 32'd9);
`else
    build_exp_from_model();
    run_sweep(1'b0, lat, bc);
    cmp_emits("b2b second");
    chk("b2b second lat", 32'(lat), 32'd15);
`endif

    // Randomized sweeps with random back-pressure against the model
    for (int it = 0; it < 25; it++) begin
      int nwr;
      if ($urandom_range(0, 3) == 0) do_clr();
      nwr = $urandom_range(0, 6);
      for (int k = 0; k < nwr; k++) begin
        hd = DW'($urandom);
        wr($urandom_range(0, DEPTH - 1), hd);
      end
      build_exp_from_model();
      run_sweep(1'b1, lat, bc);
      cmp_emits($sformatf("rand%0d", it));
      chk($sformatf("rand%0d done", it), 32'(lat > 0), 32'd1);
`ifdef RESULT_READER_CLEAR_ON_READ_EN
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
`else
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
